// File: rtl/mux_pkg.sv
// Shared definitions for the four-lane selector: select type and one-hot helper.
package mux_pkg;

   localparam int SEL_W  = 2;
   localparam int NLANES = 4;

   typedef logic [SEL_W-1:0] sel_t;

   // One-hot decode of a 2-bit select. An unknown select yields all-X so that
   // simulation exposes it instead of silently picking a lane.
   function automatic logic [NLANES-1:0] onehot4(input sel_t sel);
      logic [NLANES-1:0] oh;
      case (sel)
         2'd0:    oh = 4'b0001;
         2'd1:    oh = 4'b0010;
         2'd2:    oh = 4'b0100;
         2'd3:    oh = 4'b1000;
         default: oh = 4'bxxxx;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/mux_4to1_sel_dec.sv
// Select-to-one-hot decoder; its output drives both sel_oh and the lane gating.
module mux_4to1_sel_dec
   import mux_pkg::*;
(
   input  sel_t               s,
   output logic [NLANES-1:0]  sel_oh
);

   // Pure decode, no state.
   always_comb begin
      sel_oh = onehot4(s);
   end

endmodule

// File: rtl/mux_4to1.sv
// Four-lane selector: combinational AND-OR mux plus a load-enabled registered
// copy with valid and change flags for clocked consumers.
module mux_4to1 #(
   parameter int W      = 1,
   parameter int NLANES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           s,
   input  logic [NLANES*W-1:0]  d,
   input  logic                 en,
   output logic [W-1:0]         o,
   output logic [W-1:0]         o_q,
   output logic [NLANES-1:0]    sel_oh,
   output logic                 o_vld,
   output logic                 o_chg
);
   import mux_pkg::*;

   logic [W-1:0] o_reg_d, o_reg_q;
   logic         vld_d, vld_q;
   logic         chg_d, chg_q;

   mux_4to1_sel_dec u_sel_dec (
      .s      (sel_t'(s)),
      .sel_oh (sel_oh)
   );

   // AND-OR lane select gated by the one-hot decode; zero latency, no clock.
   always_comb begin
      o = '0;
      for (int k = 0; k < NLANES; k++) begin
         o = o | ({W{sel_oh[k]}} & d[k*W +: W]);
      end
   end

   // Next-state for the registered copy: load on en, change pulse lasts one cycle.
   always_comb begin
      o_reg_d = o_reg_q;
      vld_d   = vld_q;
      chg_d   = 1'b0;
      if (en) begin
         o_reg_d = o;
         vld_d   = 1'b1;
         chg_d   = (o != o_reg_q) || !vld_q;
      end
   end

   // Output register bank; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_reg_q <= '0;
         vld_q   <= 1'b0;
         chg_q   <= 1'b0;
      end else begin
         o_reg_q <= o_reg_d;
         vld_q   <= vld_d;
         chg_q   <= chg_d;
      end
   end

   assign o_q   = o_reg_q;
   assign o_vld = vld_q;
   assign o_chg = chg_q;

endmodule

// File: tb/tb_mux_4to1.sv
// Directed bench for mux_4to1 with a W=1 and a W=8 instance; expectations are
// queued when stimulus is applied and popped at each sampling point.
module tb_mux_4to1;

   logic       clk;
   logic       rst_n;

   logic [1:0] s1;
   logic [3:0] d1;
   logic       en1;
   logic       o1, oq1, vld1, chg1;
   logic [3:0] oh1;

   logic [1:0]  s8;
   logic [31:0] d8;
   logic        en8;
   logic [7:0]  o8, oq8;
   logic        vld8, chg8;
   logic [3:0]  oh8;

   typedef struct {
      string      tag;
      logic [7:0] exp;
   } sb_t;

   sb_t sb[$];
   int  n_cmp;
   int  n_fail;

   mux_4to1 #(.W(1), .NLANES(4)) u_w1 (
      .clk(clk), .rst_n(rst_n), .s(s1), .d(d1), .en(en1),
      .o(o1), .o_q(oq1), .sel_oh(oh1), .o_vld(vld1), .o_chg(chg1)
   );

   mux_4to1 #(.W(8), .NLANES(4)) u_w8 (
      .clk(clk), .rst_n(rst_n), .s(s8), .d(d8), .en(en8),
      .o(o8), .o_q(oq8), .sel_oh(oh8), .o_vld(vld8), .o_chg(chg8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input string tag, input logic [7:0] v);
      sb_t it;
      it.tag = tag;
      it.exp = v;
      sb.push_back(it);
   endtask

   task automatic check(input logic [7:0] obs);
      sb_t it;
      n_cmp++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed %0h with nothing expected", obs);
      end else begin
         it = sb.pop_front();
         assert (obs === it.exp)
         else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", it.tag, obs, it.exp);
         end
      end
   endtask

   task automatic expect_regs(input string tag, input logic [7:0] q,
                              input logic v, input logic c);
      push({tag, " o_q"},   q);
      push({tag, " o_vld"}, {7'b0, v});
      push({tag, " o_chg"}, {7'b0, c});
   endtask

   task automatic check_regs8();
      check(oq8);
      check({7'b0, vld8});
      check({7'b0, chg8});
   endtask

   initial begin
      logic [3:0] pats [4];
      logic [7:0] lanes8 [4];
      logic [3:0] pat;

      pats[0] = 4'b1001; pats[1] = 4'b0110; pats[2] = 4'b1111; pats[3] = 4'b0000;
      lanes8[0] = 8'hAA; lanes8[1] = 8'hBB; lanes8[2] = 8'hCC; lanes8[3] = 8'hDD;

      n_cmp  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      s1 = 2'd0; d1 = 4'b0; en1 = 1'b0;
      s8 = 2'd0; d8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA}; en8 = 1'b0;

      // Reset state before any clock edge has occurred.
      #1;
      expect_regs("reset_no_clk", 8'h00, 1'b0, 1'b0);
      check_regs8();

      // W=1 combinational sweeps.
      for (int p = 0; p < 4; p++) begin
         pat = pats[p];
         d1  = pat;
         for (int k = 0; k < 4; k++) begin
            s1 = 2'(k);
            push($sformatf("w1 o d=%b s=%0d", pat, k), {7'b0, pat[k]});
            push($sformatf("w1 sel_oh s=%0d", k), {4'b0, 4'(1 << k)});
            #100;
            check({7'b0, o1});
            check({4'b0, oh1});
         end
      end

      // W=8 combinational sweep.
      for (int k = 0; k < 4; k++) begin
         s8 = 2'(k);
         push($sformatf("w8 o s=%0d", k), lanes8[k]);
         push($sformatf("w8 sel_oh s=%0d", k), {4'b0, 4'(1 << k)});
         #3;
         check(o8);
         check({4'b0, oh8});
      end

      // Registered path.
      @(negedge clk);
      rst_n = 1'b1;
      s8 = 2'd2; en8 = 1'b1;
      expect_regs("first_load", 8'hCC, 1'b1, 1'b1);
      @(negedge clk);
      check_regs8();

      expect_regs("reload_same", 8'hCC, 1'b1, 1'b0);
      @(negedge clk);
      check_regs8();

      s8 = 2'd3; en8 = 1'b0;
      expect_regs("hold_en0", 8'hCC, 1'b1, 1'b0);
      @(negedge clk);
      check_regs8();

      // Mid-operation reset pulse between edges.
      #2;
      rst_n = 1'b0;
      #1;
      expect_regs("mid_reset", 8'h00, 1'b0, 1'b0);
      push("mid_reset o_unaffected", 8'hDD);
      push("mid_reset sel_oh_unaffected", 8'h08);
      check_regs8();
      check(o8);
      check({4'b0, oh8});
      #1;
      rst_n = 1'b1;

      @(negedge clk);
      s8 = 2'd0; en8 = 1'b1;
      expect_regs("load_after_reset", 8'hAA, 1'b1, 1'b1);
      @(negedge clk);
      check_regs8();

      s8 = 2'd1;
      expect_regs("load_changed", 8'hBB, 1'b1, 1'b1);
      @(negedge clk);
      check_regs8();

      en8 = 1'b0;
      expect_regs("chg_clears", 8'hBB, 1'b1, 1'b0);
      @(negedge clk);
      check_regs8();

      n_cmp++;
      assert (sb.size() == 0)
      else begin
         n_fail++;
         $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_4to1.md
Name: mux_4to1

Overview:
- Four-lane, one-of-four data selector.
- Combinational output `o` follows `d` lane `s` with no clock dependency. This is the primary datapath, usable in unclocked test environments.
- Also provides a registered copy with load enable, a one-hot decode of the select, and a change flag for downstream clocked logic.
- Leaf cell used wherever a small lane-select is needed.

Parameters:
- W, 1, width of each data lane in bits.
- NLANES, 4, number of lanes; fixed at 4 for this block, with select width 2.

Ports:
- clk  input  1  rising-edge clock for registered outputs only
- rst_n  input  1  asynchronous active-low reset
- s  input  2  lane select
- d  input  4*W  packed lanes; lane k = d[k*W +: W]
- en  input  1  load enable for registered output
- o  output  W  combinational selected lane
- o_q  output  W  registered selected lane
- sel_oh  output  4  combinational one-hot of s
- o_vld  output  1  registered: o_q holds a loaded value
- o_chg  output  1  registered one-cycle pulse: the last load changed o_q

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low; it asserts immediately and is released synchronously to `clk`.
- o = d[s*W +: W], purely combinational, zero latency.
  - With W=1, o = d[s].
  - s=0 selects bit 0 (LSB); s=3 selects bit 3.
- sel_oh = 4'b0001 << s, combinational; exactly one bit is always set.
- X/Z on s: o and sel_oh may be X in simulation. No latch may be inferred; use full case coverage with a default.
- Reset (rst_n=0, asynchronous):
  - o_q = 0, o_vld = 0, o_chg = 0 immediately, independent of clk.
  - o and sel_oh are unaffected by reset.
- On a rising clk edge with rst_n=1:
  - en=1: o_q <= o (the value of o sampled at the edge); o_vld <= 1; o_chg <= (o != o_q) || !o_vld.
    - The first load after reset always pulses o_chg.
  - en=0: o_q and o_vld hold; o_chg <= 0.
- Latency: o is 0 cycles; o_q, o_vld and o_chg are 1 cycle after the enabled edge.
- Simultaneous s and d change at an edge: the registered path captures the values settled before the edge (standard setup semantics).
- Reset mid-operation: all registered state clears at once. The next enabled edge behaves as a first load.
- No handshake or backpressure; en is a plain load strobe.

Decomposition:
- Shared package `mux_pkg` holds:
  - localparam SEL_W = 2
  - localparam NLANES = 4
  - typedef sel_t (logic [1:0])
  - function onehot4(sel_t) returning logic [3:0]
- Natural sub-module: `mux_4to1_sel_dec`, the combinational select-to-one-hot decoder. It drives both sel_oh and the lane AND-OR select.
- The top level holds the AND-OR mux and the output register bank.

Test Plan:
- W=1, d=4'b1001, en=0; s swept 0,1,2,3 with 100 ns hold each, no clock required -> o = 1,0,0,1; sel_oh = 0001,0010,0100,1000.
- W=1, d=4'b0110, s swept 0..3 -> o = 0,1,1,0. Then d=4'b1111 -> o=1 for every s; d=4'b0000 -> o=0 for every s.
- W=8, d={8'hDD,8'hCC,8'hBB,8'hAA}, s=0..3 -> o = AA,BB,CC,DD.
- Reset and registered path, W=8 with the lanes above:
  - rst_n=0 -> o_q=0, o_vld=0, o_chg=0, asserted without any clk edge.
  - Release reset; s=2, en=1 at one edge -> next cycle o_q=CC, o_vld=1, o_chg=1.
  - en=1 again with s=2 unchanged -> o_chg=0.
  - en=0 with s=3 -> o_q stays CC, o_chg=0.
- Mid-operation reset, W=8: with o_q=CC and o_vld=1, pulse rst_n low between edges -> o_q=0 and o_vld=0 at once. Next en=1 edge with s=0 -> o_q=AA, o_chg=1.
